vend_controller: RTL and testbench

//  Parametrised vending-machine control FSM. Takes debounced single-cycle key

---
 rtl/vend_controller.sv | 217 +++++++++++++++++++++
 tb/tb_vend_controller.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vend_controller.sv
// Vending-machine control FSM: product select, quantity, coin payment, vend,
// then change or refund. Tracks per-product stock and an inactivity timeout.
module vend_controller #(
  parameter int unsigned NUM_PRODUCTS = 5,
  parameter int unsigned PRICE_W      = 8,
  parameter logic [NUM_PRODUCTS*PRICE_W-1:0] PRICES = 40'h02080A0C0F,
  parameter int unsigned QTY_MAX      = 9,
  parameter int unsigned STOCK_INIT   = 4,
  parameter int unsigned TIMEOUT_CYC  = 1000,
  localparam int unsigned IDX_W = (NUM_PRODUCTS > 1) ? $clog2(NUM_PRODUCTS) : 1,
  localparam int unsigned TOT_W = PRICE_W + 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    key_valid,
  input  logic [3:0]              key_code,
  input  logic                    restock,
  output logic [TOT_W-1:0]        disp_value,
  output logic [2:0]              state_o,
  output logic                    vend,
  output logic [IDX_W-1:0]        vend_id,
  output logic [3:0]              vend_qty,
  output logic                    change_valid,
  output logic [TOT_W-1:0]        change_amt,
  output logic                    err,
  output logic [NUM_PRODUCTS-1:0] sold_out
);

  localparam logic [3:0] K_ENTER  = 4'hA;
  localparam logic [3:0] K_CANCEL = 4'hB;
  localparam logic [3:0] K_COIN2  = 4'hC;
  localparam logic [3:0] K_COIN5  = 4'hD;
  localparam logic [3:0] K_COIN10 = 4'hE;
  localparam logic [3:0] K_TAKE   = 4'hF;
  localparam int unsigned CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SEL  = 3'd1,
    ST_QTY  = 3'd2,
    ST_PAY  = 3'd3,
    ST_VEND = 3'd4,
    ST_DONE = 3'd5
  } state_t;

  state_t state, state_next;

  logic [IDX_W-1:0] sel;
  logic [3:0]       qty;
  logic [TOT_W-1:0] total;
  logic [TOT_W-1:0] credit;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       stock [NUM_PRODUCTS];

  logic             is_digit, is_coin, key_enter, key_cancel, key_take;
  logic             sel_ok, qty_ok, enter_ok, paid, timed, tmo, err_next;
  logic [3:0]       key_stock, cur_stock;
  logic [PRICE_W-1:0] cur_price;
  logic [TOT_W-1:0] order_amt, coin_val;
  logic [TOT_W:0]   credit_sum;

  assign is_digit   = key_valid && (key_code <= 4'd9);
  assign is_coin    = key_valid && (key_code >= K_COIN2) && (key_code <= K_COIN10);
  assign key_enter  = key_valid && (key_code == K_ENTER);
  assign key_cancel = key_valid && (key_code == K_CANCEL);
  assign key_take   = key_valid && (key_code == K_TAKE);

  // Table lookups by loop so out-of-range indices simply read as zero.
  always_comb begin
    key_stock = '0;
    cur_stock = '0;
    cur_price = '0;
    for (int unsigned i = 0; i < NUM_PRODUCTS; i++) begin
      if (32'(key_code) == i) key_stock = stock[i];
      if (32'(sel) == i) begin
        cur_stock = stock[i];
        cur_price = PRICES[i*PRICE_W +: PRICE_W];
      end
    end
  end

  always_comb begin
    coin_val = '0;
    case (key_code)
      K_COIN2:  coin_val = TOT_W'(2);
      K_COIN5:  coin_val = TOT_W'(5);
      K_COIN10: coin_val = TOT_W'(10);
      default:  coin_val = '0;
    endcase
  end

  assign sel_ok     = (32'(key_code) < NUM_PRODUCTS) && (key_stock != 4'd0);
  assign qty_ok     = (key_code != 4'd0) && (32'(key_code) <= QTY_MAX);
  assign enter_ok   = (qty <= cur_stock);
  assign order_amt  = {4'b0, cur_price} * {{PRICE_W{1'b0}}, qty};
  assign paid       = (credit >= total);
  assign credit_sum = {1'b0, credit} + {1'b0, coin_val};
  assign timed      = (state == ST_SEL) || (state == ST_QTY) || (state == ST_PAY);
  assign tmo        = timed && !key_valid && (cnt == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (key_enter) state_next = ST_SEL;
      ST_SEL: begin
        if (is_digit && sel_ok)         state_next = ST_QTY;
        else if (key_cancel || tmo)     state_next = ST_IDLE;
      end
      ST_QTY: begin
        if (key_enter && enter_ok)      state_next = ST_PAY;
        else if (key_cancel || tmo)     state_next = ST_IDLE;
      end
      // Payment complete outranks cancel/timeout so paid credit is never refunded.
      ST_PAY: begin
        if (paid)                       state_next = ST_VEND;
        else if (key_cancel || tmo)     state_next = ST_DONE;
      end
      ST_VEND:                          state_next = ST_DONE;
      ST_DONE: if (key_take)            state_next = ST_IDLE;
      default:                          state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    err_next = is_coin && (state != ST_PAY);
    if (state == ST_SEL && is_digit && !sel_ok) err_next = 1'b1;
    if (state == ST_QTY && ((is_digit && !qty_ok) || (key_enter && !enter_ok))) err_next = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (!timed || key_valid || (state_next != state)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sel        <= '0;
      qty        <= '0;
      total      <= '0;
      credit     <= '0;
      change_amt <= '0;
      vend_id    <= '0;
      vend_qty   <= '0;
      err        <= 1'b0;
      for (int unsigned i = 0; i < NUM_PRODUCTS; i++) stock[i] <= 4'(STOCK_INIT);
    end else begin
      err <= err_next;
      case (state)
        ST_IDLE: begin
          if (restock)
            for (int unsigned i = 0; i < NUM_PRODUCTS; i++) stock[i] <= 4'(STOCK_INIT);
        end
        ST_SEL: begin
          if (is_digit && sel_ok) begin
            sel <= key_code[IDX_W-1:0];
            qty <= 4'd1;
          end
        end
        ST_QTY: begin
          if (is_digit && qty_ok)        qty   <= key_code;
          else if (key_enter && enter_ok) total <= order_amt;
        end
        ST_PAY: begin
          if (is_coin) credit <= credit_sum[TOT_W] ? '1 : credit_sum[TOT_W-1:0];
          if (paid) begin
            vend_id  <= sel;
            vend_qty <= qty;
          end else if (key_cancel || tmo) begin
            change_amt <= credit;
          end
        end
        ST_VEND: begin
          change_amt <= credit - total;
          for (int unsigned i = 0; i < NUM_PRODUCTS; i++)
            if (32'(sel) == i) stock[i] <= stock[i] - qty;
        end
        ST_DONE: begin
          if (key_take) begin
            credit     <= '0;
            total      <= '0;
            change_amt <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    disp_value   = '0;
    vend         = 1'b0;
    change_valid = 1'b0;
    state_o      = state;
    case (state)
      ST_QTY:  disp_value = order_amt;
      ST_PAY:  disp_value = paid ? '0 : (total - credit);
      ST_VEND: vend = 1'b1;
      ST_DONE: begin
        change_valid = 1'b1;
        disp_value   = change_amt;
      end
      default: ;
    endcase
    for (int unsigned i = 0; i < NUM_PRODUCTS; i++) sold_out[i] = (stock[i] == 4'd0);
  end

endmodule

// File: tb/tb_vend_controller.sv
// Bench for vend_controller: directed purchase scenarios followed by random key
// traffic, every cycle compared against a transaction-level reference model.
module tb_vend_controller;

  localparam int N     = 5;
  localparam int T     = 50;
  localparam int TOT_W = 12;
  localparam int CMAX  = (1 << TOT_W) - 1;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             key_valid = 1'b0;
  logic [3:0]       key_code = 4'h0;
  logic             restock = 1'b0;
  logic [TOT_W-1:0] disp_value;
  logic [2:0]       state_o;
  logic             vend;
  logic [2:0]       vend_id;
  logic [3:0]       vend_qty;
  logic             change_valid;
  logic [TOT_W-1:0] change_amt;
  logic             err;
  logic [N-1:0]     sold_out;

  vend_controller #(.TIMEOUT_CYC(T)) dut (
    .clk(clk), .reset(reset), .key_valid(key_valid), .key_code(key_code),
    .restock(restock), .disp_value(disp_value), .state_o(state_o), .vend(vend),
    .vend_id(vend_id), .vend_qty(vend_qty), .change_valid(change_valid),
    .change_amt(change_amt), .err(err), .sold_out(sold_out)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: machine phase as a plain number plus transaction bookkeeping.
  int price [N] = '{15, 12, 10, 8, 2};
  int m_phase, m_sel, m_qty, m_total, m_credit, m_change, m_idle, m_vid, m_vqty;
  int m_stock [N];
  bit m_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_phase = 0; m_sel = 0; m_qty = 0; m_total = 0; m_credit = 0;
    m_change = 0; m_idle = 0; m_vid = 0; m_vqty = 0; m_err = 0;
    for (int i = 0; i < N; i++) m_stock[i] = 4;
  endfunction

  function automatic void model_step(input bit kv, input int kc, input bit rs);
    int prev = m_phase;
    bit coin = kv && kc >= 12 && kc <= 14;
    int coinv = (kc == 12) ? 2 : (kc == 13) ? 5 : 10;
    bit quit = (kv && kc == 11) || (!kv && m_idle == T - 1);
    m_err = coin && m_phase != 3;
    case (m_phase)
      0: begin
        if (rs) for (int i = 0; i < N; i++) m_stock[i] = 4;
        if (kv && kc == 10) m_phase = 1;
      end
      1: if (kv && kc <= 9) begin
           if (kc < N && m_stock[kc] > 0) begin m_sel = kc; m_qty = 1; m_phase = 2; end
           else m_err = 1;
         end else if (quit) m_phase = 0;
      2: if (kv && kc <= 9) begin
           if (kc >= 1) m_qty = kc; else m_err = 1;
         end else if (kv && kc == 10) begin
           if (m_qty <= m_stock[m_sel]) begin m_total = price[m_sel] * m_qty; m_phase = 3; end
           else m_err = 1;
         end else if (quit) m_phase = 0;
      3: begin
        bit covered = m_credit >= m_total;
        if (coin) m_credit = (m_credit + coinv > CMAX) ? CMAX : m_credit + coinv;
        if (covered) begin m_phase = 4; m_vid = m_sel; m_vqty = m_qty; end
        else if (quit) begin m_change = m_credit; m_phase = 5; end
      end
      4: begin
        m_stock[m_sel] -= m_qty;
        m_change = m_credit - m_total;
        m_phase = 5;
      end
      default: if (kv && kc == 15) begin
        m_phase = 0; m_credit = 0; m_total = 0; m_change = 0;
      end
    endcase
    if (kv || m_phase != prev || m_phase == 0 || m_phase >= 4) m_idle = 0;
    else m_idle++;
  endfunction

  task automatic compare_all();
    int disp = 0;
    logic [N-1:0] so;
    if (m_phase == 2) disp = price[m_sel] * m_qty;
    if (m_phase == 3 && m_credit < m_total) disp = m_total - m_credit;
    if (m_phase == 5) disp = m_change;
    for (int i = 0; i < N; i++) so[i] = (m_stock[i] == 0);
    check("state", 32'(state_o), m_phase);
    check("disp", 32'(disp_value), disp);
    check("vend", 32'(vend), (m_phase == 4) ? 1 : 0);
    check("vend_id", 32'(vend_id), m_vid);
    check("vend_qty", 32'(vend_qty), m_vqty);
    check("change_valid", 32'(change_valid), (m_phase == 5) ? 1 : 0);
    check("change_amt", 32'(change_amt), m_change);
    check("err", 32'(err), 32'(m_err));
    check("sold_out", 32'(sold_out), 32'(so));
  endtask

  // Inputs change at the falling edge; outputs are compared at the next falling edge.
  task automatic cycle(input bit kv, input logic [3:0] kc, input bit rs);
    key_valid = kv; key_code = kc; restock = rs;
    @(posedge clk);
    model_step(kv, int'(kc), rs);
    @(negedge clk);
    key_valid = 1'b0; key_code = 4'h0; restock = 1'b0;
    compare_all();
  endtask

  task automatic key(input logic [3:0] kc);
    cycle(1'b1, kc, 1'b0);
    cycle(1'b0, 4'h0, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 4'h0, 1'b0);
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    check("reset_state", 32'(state_o), 0);
    check("reset_err", 32'(err), 0);
    check("reset_sold_out", 32'(sold_out), 0);
    reset = 1'b1;
    idle(2);

    // T1: product 0, qty 2, exact payment
    key(4'hA); key(4'h0);
    check("t1_disp_q1", 32'(disp_value), 15);
    key(4'h2);
    check("t1_disp_q2", 32'(disp_value), 30);
    key(4'hA); key(4'hE); key(4'hE); key(4'hE);
    check("t1_vend", 32'(vend), 1);
    check("t1_vend_id", 32'(vend_id), 0);
    check("t1_vend_qty", 32'(vend_qty), 2);
    idle(1);
    check("t1_state_done", 32'(state_o), 5);
    check("t1_change", 32'(change_amt), 0);
    key(4'hF);

    // T2: product 3, overpay by 2
    key(4'hA); key(4'h3); key(4'hA); key(4'hE);
    check("t2_vend_id", 32'(vend_id), 3);
    idle(1);
    check("t2_change", 32'(change_amt), 2);
    check("t2_disp", 32'(disp_value), 2);
    key(4'hF);
    check("t2_idle_disp", 32'(disp_value), 0);
    check("t2_idle_cv", 32'(change_valid), 0);

    // T3: invalid product, sell out product 4, restock
    key(4'hA);
    cycle(1'b1, 4'h7, 1'b0);
    check("t3_err_bad_digit", 32'(err), 1);
    cycle(1'b0, 4'h0, 1'b0);
    check("t3_err_one_cycle", 32'(err), 0);
    check("t3_stay_sel", 32'(state_o), 1);
    key(4'hB);
    for (int n = 0; n < 4; n++) begin
      key(4'hA); key(4'h4); key(4'hA); key(4'hC); idle(1); key(4'hF);
    end
    check("t3_sold_out4", 32'(sold_out[4]), 1);
    key(4'hA);
    cycle(1'b1, 4'h4, 1'b0);
    check("t3_err_sold", 32'(err), 1);
    cycle(1'b0, 4'h0, 1'b0);
    key(4'hB);
    cycle(1'b0, 4'h0, 1'b1);
    check("t3_restock", 32'(sold_out), 0);

    // T4: cancel refund, then timeout refund
    key(4'hA); key(4'h1); key(4'hA); key(4'hD); key(4'hB);
    check("t4_cancel_state", 32'(state_o), 5);
    check("t4_cancel_refund", 32'(change_amt), 5);
    key(4'hF);
    key(4'hA); key(4'h1); key(4'hA); key(4'hD);
    for (int n = 0; n < T + 5 && state_o != 3'd5; n++) cycle(1'b0, 4'h0, 1'b0);
    check("t4_timeout_state", 32'(state_o), 5);
    check("t4_timeout_refund", 32'(change_amt), 5);
    key(4'hF);

    // T5: quantity above stock, zero quantity, then valid order
    key(4'hA); key(4'h2); key(4'h5);
    cycle(1'b1, 4'hA, 1'b0);
    check("t5_err_stock", 32'(err), 1);
    check("t5_stay_qty", 32'(state_o), 2);
    cycle(1'b0, 4'h0, 1'b0);
    cycle(1'b1, 4'h0, 1'b0);
    check("t5_err_zero", 32'(err), 1);
    cycle(1'b0, 4'h0, 1'b0);
    key(4'h3); key(4'hA);
    check("t5_pay", 32'(state_o), 3);
    check("t5_total", 32'(disp_value), 30);

    // T6: asynchronous reset in PAY with credit 10
    key(4'hE);
    #2 reset = 1'b0;
    #1;
    model_reset();
    check("t6_async_state", 32'(state_o), 0);
    check("t6_async_disp", 32'(disp_value), 0);
    check("t6_async_cv", 32'(change_amt), 0);
    @(negedge clk); @(negedge clk);
    reset = 1'b1;
    idle(1);
    key(4'hA); key(4'h0); key(4'h4); key(4'hA);
    check("t6_stock_restored", 32'(state_o), 3);
    key(4'hB); key(4'hF);

    // Key arriving in the exact expiry cycle wins; afterwards the timeout fires
    cycle(1'b1, 4'hA, 1'b0);
    idle(T - 1);
    cycle(1'b1, 4'h9, 1'b0);
    check("exp_key_wins", 32'(state_o), 1);
    idle(T - 1);
    check("exp_not_yet", 32'(state_o), 1);
    idle(1);
    check("exp_timeout", 32'(state_o), 0);

    // Random traffic
    for (int n = 0; n < 4000; n++) begin
      int r = int'($urandom_range(0, 19));
      logic [3:0] kc;
      if (r < 6)       kc = 4'(12 + $urandom_range(0, 2));
      else if (r < 11) kc = 4'($urandom_range(0, 9));
      else if (r < 15) kc = 4'hA;
      else if (r < 16) kc = 4'hB;
      else             kc = 4'hF;
      if ($urandom_range(0, 150) == 0) idle(T + 2);
      cycle($urandom_range(0, 2) == 0, kc, $urandom_range(0, 29) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
